// File: rtl/evo_add_gene_stream.sv
`default_nettype none
// ============================================================================
// Module      : evo_add_gene_stream
// Description : Streaming add-node / add-connection mutation engine with a
//               3-entry output buffer. Optional stats: EVO_ADD_GENE_STATS_EN.
// Revision    : 1.0
// ============================================================================
module evo_add_gene_stream #(
    parameter int              ID_W       = 8,
    parameter int              WT_W       = 32,
    parameter int              GENE_W     = 64,
    parameter int              THR_W      = 32,
    parameter logic [WT_W-1:0] DEF_WEIGHT = 32'hC0C0C0C0,
    parameter int              ID_INIT    = 5
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [GENE_W-1:0]   in_gene_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*THR_W-1:0]  rand_i,
    input  logic [THR_W-1:0]    cfg_node_thr_i,
    input  logic [THR_W-1:0]    cfg_conn_thr_i,
    output logic [GENE_W-1:0]   out_gene_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                id_ovf_o
`ifdef EVO_ADD_GENE_STATS_EN
    ,
    output logic [15:0]         nodes_added_o,
    output logic [15:0]         conns_added_o
`endif
);

    localparam int GID_LSB  = GENE_W - ID_W;
    localparam int TYPE_BIT = GID_LSB - 1;
    localparam int ATTR_LSB = GID_LSB - 3;
    localparam int SRC_LSB  = WT_W + ID_W;
    localparam int DST_LSB  = WT_W;
    localparam logic [ID_W-1:0] ID_RST = ID_W'(ID_INIT);
    localparam logic [ID_W-1:0] ID_ONE = ID_W'(1);

    typedef enum logic [0:0] {S_EMPTY = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t              state_q;
    logic [1:0]          count_q;
    logic [GENE_W-1:0]   buf_q [3];
    logic [ID_W-1:0]     next_id_q;
    logic [ID_W-1:0]     prev_id_q;
    logic                prev_valid_q;
    logic                id_ovf_q;
`ifdef EVO_ADD_GENE_STATS_EN
    logic [15:0]         nodes_q;
    logic [15:0]         conns_q;
    assign nodes_added_o = nodes_q;
    assign conns_added_o = conns_q;
`endif

    logic [ID_W-1:0]   w_gid, w_src, w_dst;
    logic              w_type;
    logic [1:0]        w_attr;
    logic [WT_W-1:0]   w_wt;
    logic              w_is_term, w_split_req, w_do_split, w_do_conn;
    logic              w_acc, w_drn;
    logic [GENE_W-1:0] w_gen [3];
    logic [1:0]        w_gen_n;

    assign w_gid  = in_gene_i[GENE_W-1:GID_LSB];
    assign w_type = in_gene_i[TYPE_BIT];
    assign w_attr = in_gene_i[ATTR_LSB+1:ATTR_LSB];
    assign w_src  = in_gene_i[SRC_LSB+ID_W-1:SRC_LSB];
    assign w_dst  = in_gene_i[DST_LSB+ID_W-1:DST_LSB];
    assign w_wt   = in_gene_i[WT_W-1:0];

    assign w_is_term   = &w_gid;
    assign w_split_req = w_type && !w_is_term && (rand_i[THR_W-1:0] > cfg_node_thr_i);
    assign w_do_split  = w_split_req && (next_id_q != '1);
    assign w_do_conn   = !w_type && !w_is_term && prev_valid_q &&
                         (rand_i[2*THR_W-1:THR_W] > cfg_conn_thr_i);

    assign in_ready_o  = reset_ni && ((count_q == 2'd0) || (count_q == 2'd1 && out_ready_i));
    assign w_acc       = in_valid_i && in_ready_o;
    assign w_drn       = out_valid_o && out_ready_i;
    assign out_valid_o = (state_q == S_DRAIN);
    assign out_gene_o  = buf_q[0];
    assign id_ovf_o    = id_ovf_q;

    // Generated genes carry zeroed reserved bits.
    function automatic logic [GENE_W-1:0] mk_gene(
        input logic [ID_W-1:0] gid, input logic typ, input logic [1:0] attr,
        input logic [ID_W-1:0] src, input logic [ID_W-1:0] dst, input logic [WT_W-1:0] wt);
        logic [GENE_W-1:0] g;
        g = '0;
        g[GENE_W-1:GID_LSB]          = gid;
        g[TYPE_BIT]                  = typ;
        g[ATTR_LSB+1:ATTR_LSB]       = attr;
        g[SRC_LSB+ID_W-1:SRC_LSB]    = src;
        g[DST_LSB+ID_W-1:DST_LSB]    = dst;
        g[WT_W-1:0]                  = wt;
        return g;
    endfunction

    always_comb begin
        w_gen[0] = in_gene_i;
        w_gen[1] = '0;
        w_gen[2] = '0;
        w_gen_n  = 2'd1;
        if (w_do_split) begin
            w_gen[0] = mk_gene(w_gid, 1'b1, w_attr, w_src, next_id_q, w_wt);
            w_gen[1] = mk_gene(w_gid, 1'b0, w_attr, next_id_q, '0, DEF_WEIGHT);
            w_gen[2] = mk_gene(w_gid, 1'b1, w_attr, next_id_q, w_dst, DEF_WEIGHT);
            w_gen_n  = 2'd3;
        end else if (w_do_conn) begin
            w_gen[1] = mk_gene(w_gid, 1'b1, 2'b00, w_src, prev_id_q, DEF_WEIGHT);
            w_gen_n  = 2'd2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q      <= S_EMPTY;
            count_q      <= 2'd0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
            next_id_q    <= ID_RST;
            prev_id_q    <= '0;
            prev_valid_q <= 1'b0;
            id_ovf_q     <= 1'b0;
`ifdef EVO_ADD_GENE_STATS_EN
            nodes_q      <= '0;
            conns_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_EMPTY: if (w_acc) state_q <= S_DRAIN;
                S_DRAIN: if (!w_acc && w_drn && count_q == 2'd1) state_q <= S_EMPTY;
                default: state_q <= S_EMPTY;
            endcase

            // An accept only happens with the buffer empty or about to be, so
            // the generated genes simply replace its contents.
            if (w_acc) begin
                for (int i = 0; i < 3; i++) buf_q[i] <= w_gen[i];
                count_q <= w_gen_n;
                if (w_is_term) begin
                    next_id_q    <= ID_RST;
                    prev_valid_q <= 1'b0;
                    id_ovf_q     <= 1'b0;
`ifdef EVO_ADD_GENE_STATS_EN
                    nodes_q      <= '0;
                    conns_q      <= '0;
`endif
                end else if (!w_type) begin
                    if (w_src >= next_id_q) next_id_q <= (&w_src) ? w_src : w_src + ID_ONE;
                    prev_id_q    <= w_src;
                    prev_valid_q <= 1'b1;
`ifdef EVO_ADD_GENE_STATS_EN
                    if (w_do_conn && conns_q != 16'hFFFF) conns_q <= conns_q + 16'd1;
`endif
                end else if (w_do_split) begin
                    next_id_q <= next_id_q + ID_ONE;
`ifdef EVO_ADD_GENE_STATS_EN
                    if (nodes_q != 16'hFFFF) nodes_q <= nodes_q + 16'd1;
`endif
                end else if (w_split_req) begin
                    id_ovf_q <= 1'b1;
                end
            end else if (w_drn) begin
                buf_q[0] <= buf_q[1];
                buf_q[1] <= buf_q[2];
                buf_q[2] <= '0;
                count_q  <= count_q - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_evo_add_gene_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_evo_add_gene_stream
// Description : Scoreboard bench for evo_add_gene_stream with directed genes.
// Revision    : 1.0
// ============================================================================
module tb_evo_add_gene_stream;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] HI   = 32'h8000_0000;
    localparam logic [31:0] LO   = 32'h1000_0000;

    logic        clk;
    logic        reset_n;
    logic [63:0] in_gene;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] rnd;
    logic [31:0] node_thr, conn_thr;
    logic [63:0] out_gene;
    logic        out_valid;
    logic        out_ready;
    logic        id_ovf;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb [$];

    evo_add_gene_stream dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .in_gene_i      (in_gene),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .rand_i         (rnd),
        .cfg_node_thr_i (node_thr),
        .cfg_conn_thr_i (conn_thr),
        .out_gene_o     (out_gene),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .id_ovf_o       (id_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every presented gene must match the scoreboard head.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%h required=none", out_gene);
            end else begin
                chk("out_gene", out_gene, sb[0]);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Called and returning at posedge+1; accept happens on the preceding edge.
    task automatic send(input logic [63:0] g, input logic [31:0] rn, input logic [31:0] rc,
                        input logic [31:0] nthr, input logic [31:0] cthr);
        int n = 0;
        in_gene  = g;
        rnd      = {rc, rn};
        node_thr = nthr;
        conn_thr = cthr;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_gene = '0; rnd = '0;
        node_thr = ONES; conn_thr = ONES; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_gene",  out_gene,  0);
        chk("rst_id_ovf",    id_ovf,    0);
        @(posedge clk); #1; reset_n = 1'b1;
        @(posedge clk); #1;

        // Pass-through, back to back; node 6 moves next_id to 7
        sb.push_back(64'h0100_0600_0000_0000);
        send(64'h0100_0600_0000_0000, ONES, ONES, ONES, ONES);
        sb.push_back(64'h0280_0605_1234_5678);
        send(64'h0280_0605_1234_5678, ONES, ONES, ONES, ONES);
        @(negedge clk);
        chk("pass_second_valid", out_valid, 1);
        wait_drain();

        // Split with next_id=7
        sb.push_back(64'h0380_0607_1234_5678);
        sb.push_back(64'h0300_0700_C0C0_C0C0);
        sb.push_back(64'h0380_0705_C0C0_C0C0);
        send(64'h0380_0605_1234_5678, HI, ONES, LO, ONES);
        @(negedge clk);
        chk("split_latency", out_valid, 1);
        chk("split_rdy_c1", in_ready, 0);
        @(negedge clk);
        chk("split_rdy_c2", in_ready, 0);
        @(negedge clk);
        chk("split_rdy_c3", in_ready, 1);
        wait_drain();

        // Draw equal to threshold: no mutation of either kind
        sb.push_back(64'h0480_0102_AAAA_5555);
        send(64'h0480_0102_AAAA_5555, LO, ONES, LO, ONES);
        sb.push_back(64'h0500_0400_0000_0000);
        send(64'h0500_0400_0000_0000, ONES, LO, ONES, LO);
        wait_drain();

        // Add-connection: node 3 then node 9
        sb.push_back(64'h0600_0300_0000_0000);
        send(64'h0600_0300_0000_0000, ONES, ONES, ONES, ONES);
        sb.push_back(64'h0700_0900_0000_0000);
        sb.push_back(64'h0780_0903_C0C0_C0C0);
        send(64'h0700_0900_0000_0000, ONES, 32'h9000_0000, ONES, 32'h2000_0000);
        wait_drain();

        // Backpressure during split; next_id=10 proves the add-connection step
        out_ready = 1'b0;
        sb.push_back(64'h0880_010A_0000_0011);
        sb.push_back(64'h0800_0A00_C0C0_C0C0);
        sb.push_back(64'h0880_0A02_C0C0_C0C0);
        send(64'h0880_0102_0000_0011, HI, ONES, LO, ONES);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        wait_drain();

        // Overflow: node FE saturates next_id, split request forwards unchanged
        sb.push_back(64'h0900_FE00_0000_0000);
        send(64'h0900_FE00_0000_0000, ONES, ONES, ONES, ONES);
        sb.push_back(64'h0A80_0102_0000_0022);
        send(64'h0A80_0102_0000_0022, HI, ONES, LO, ONES);
        @(negedge clk);
        chk("ovf_set", id_ovf, 1);
        wait_drain();
        sb.push_back(64'hFF00_0000_0000_0000);
        send(64'hFF00_0000_0000_0000, HI, HI, LO, LO);
        @(negedge clk);
        chk("ovf_clear", id_ovf, 0);
        wait_drain();

        // next_id back to 5 after terminator
        sb.push_back(64'h0B80_0105_0000_0033);
        sb.push_back(64'h0B00_0500_C0C0_C0C0);
        sb.push_back(64'h0B80_0502_C0C0_C0C0);
        send(64'h0B80_0102_0000_0033, HI, ONES, LO, ONES);
        wait_drain();
        // prev_valid was cleared by terminator: no connection on first node
        sb.push_back(64'h0C00_0200_0000_0000);
        send(64'h0C00_0200_0000_0000, ONES, ONES, ONES, 32'h0);
        // Threshold all-ones disables even with all-ones draw
        sb.push_back(64'h0D00_0400_0000_0000);
        send(64'h0D00_0400_0000_0000, ONES, ONES, ONES, ONES);
        wait_drain();

        // Reset mid-drain (next_id=6)
        sb.push_back(64'h1080_0706_0000_0055);
        sb.push_back(64'h1000_0600_C0C0_C0C0);
        sb.push_back(64'h1080_0608_C0C0_C0C0);
        send(64'h1080_0708_0000_0055, HI, ONES, LO, ONES);
        @(posedge clk); #1;
        reset_n = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_gene",  out_gene,  0);
        chk("midrst_in_ready",  in_ready,  0);
        @(posedge clk); #1; reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_count0", in_ready, 1);
        @(posedge clk); #1; out_ready = 1'b1;
        sb.push_back(64'h0E80_0305_0000_0044);
        sb.push_back(64'h0E00_0500_C0C0_C0C0);
        sb.push_back(64'h0E80_0504_C0C0_C0C0);
        send(64'h0E80_0304_0000_0044, HI, ONES, LO, ONES);
        wait_drain();

        chk("sb_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
